// File: rtl/rf_seq_defs.sv
// -----------------------------------------------------------------------------
// rf_seq_defs
//   Shared definitions for the register-file micro-op sequencer:
//   opcode encodings, FSM state encoding and small opcode classifiers.
//   No ports (package).
// -----------------------------------------------------------------------------
package rf_seq_defs;

    localparam logic [3:0] OP_MOV  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_NOT  = 4'h6;
    localparam logic [3:0] OP_INC  = 4'h7;
    localparam logic [3:0] OP_DEC  = 4'h8;
    localparam logic [3:0] OP_SHL  = 4'h9;
    localparam logic [3:0] OP_SHR  = 4'hA;
    localparam logic [3:0] OP_SWAP = 4'hB;
    localparam logic [3:0] OP_CLR  = 4'hC;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        EXEC = 3'd2,
        WB   = 3'd3,
        WB2  = 3'd4,
        ERR  = 3'd5
    } state_t;

    // 0xD..0xF are unassigned and take the error path.
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_CLR);
    endfunction

    // Ops 0..A update N, Z and C from the ALU result; SWAP/CLR do not.
    function automatic logic op_sets_nzc(input logic [3:0] op);
        return (op <= OP_SHR);
    endfunction

endpackage

// File: rtl/rf_op_sequencer_if.sv
// -----------------------------------------------------------------------------
// rf_op_sequencer_if
//   Bundles the micro-op handshake, the register-file bus and the status
//   outputs of the sequencer.
//   Signals:
//     op_valid/op_ready/op_code/op_rd/op_rs1/op_rs2 : micro-op handshake
//     R_Adr/S_Adr, DA/DB                            : register-file read ports
//     W_Adr/W/we                                    : register-file write port
//     done/err, flag_n/flag_z/flag_c                : completion and status
//   Modports:
//     master : the sequencer (drives read/write addresses, handshake ready)
//     slave  : the environment (decoder + register file)
// -----------------------------------------------------------------------------
interface rf_op_sequencer_if #(
    parameter int DW = 16,
    parameter int AW = 3
);
    logic          op_valid;
    logic          op_ready;
    logic [3:0]    op_code;
    logic [AW-1:0] op_rd;
    logic [AW-1:0] op_rs1;
    logic [AW-1:0] op_rs2;
    logic [AW-1:0] R_Adr;
    logic [AW-1:0] S_Adr;
    logic [DW-1:0] DA;
    logic [DW-1:0] DB;
    logic [AW-1:0] W_Adr;
    logic [DW-1:0] W;
    logic          we;
    logic          done;
    logic          err;
    logic          flag_n;
    logic          flag_z;
    logic          flag_c;

    modport master (
        input  op_valid, op_code, op_rd, op_rs1, op_rs2, DA, DB,
        output op_ready, R_Adr, S_Adr, W_Adr, W, we, done, err,
               flag_n, flag_z, flag_c
    );

    modport slave (
        output op_valid, op_code, op_rd, op_rs1, op_rs2, DA, DB,
        input  op_ready, R_Adr, S_Adr, W_Adr, W, we, done, err,
               flag_n, flag_z, flag_c
    );
endinterface

// File: rtl/rf_seq_alu.sv
// -----------------------------------------------------------------------------
// rf_seq_alu
//   Combinational ALU for the sequencer.
//   Ports:
//     i_op  [3:0]   operation code
//     i_a   [DW-1:0] operand A (from rs1)
//     i_b   [DW-1:0] operand B (from rs2)
//     o_res [DW-1:0] result, modulo 2**DW
//     o_c            carry / borrow / shifted-out bit (0 for logic ops)
// -----------------------------------------------------------------------------
module rf_seq_alu
    import rf_seq_defs::*;
#(
    parameter int DW = 16
) (
    input  logic [3:0]    i_op,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [DW-1:0] o_res,
    output logic          o_c
);

    localparam logic [DW:0] ONE = {{DW{1'b0}}, 1'b1};

    // One extra MSB carries carry-out / borrow; subtraction on zero-extended
    // operands leaves the MSB set exactly when A < B.
    logic [DW:0] w_ext;
    logic [DW:0] w_a;
    logic [DW:0] w_b;

    assign w_a = {1'b0, i_a};
    assign w_b = {1'b0, i_b};

    always_comb begin
        w_ext = w_a;
        case (i_op)
            OP_MOV:  w_ext = w_a;
            OP_ADD:  w_ext = w_a + w_b;
            OP_SUB:  w_ext = w_a - w_b;
            OP_AND:  w_ext = w_a & w_b;
            OP_OR:   w_ext = w_a | w_b;
            OP_XOR:  w_ext = w_a ^ w_b;
            OP_NOT:  w_ext = {1'b0, ~i_a};
            OP_INC:  w_ext = w_a + ONE;
            OP_DEC:  w_ext = w_a - ONE;
            OP_SHL:  w_ext = {i_a, 1'b0};
            OP_SHR:  w_ext = {i_a[0], 1'b0, i_a[DW-1:1]};
            OP_SWAP: w_ext = w_a;
            OP_CLR:  w_ext = '0;
            default: w_ext = w_a;
        endcase
    end

    assign o_res = w_ext[DW-1:0];
    assign o_c   = w_ext[DW];

endmodule

// File: rtl/rf_op_sequencer.sv
// -----------------------------------------------------------------------------
// rf_op_sequencer
//   Multi-cycle initiator for a register file. Accepts one register-to-register
//   micro-op per handshake, reads both sources, computes the result in
//   rf_seq_alu and writes it back; keeps N/Z/C status flags.
//   Ports:
//     clk   : rising-edge clock
//     reset : asynchronous, active-low reset
//     bus   : rf_op_sequencer_if.master (handshake, register-file bus, status)
//   Sequence: IDLE -> READ -> EXEC -> WB -> IDLE (SWAP adds WB2; illegal
//   opcodes take IDLE -> ERR -> IDLE).
// -----------------------------------------------------------------------------
module rf_op_sequencer
    import rf_seq_defs::*;
#(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic              clk,
    input  logic              reset,
    rf_op_sequencer_if.master bus
);

    state_t        r_state;
    state_t        w_next;

    logic [3:0]    r_op;
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_rs1;
    logic [AW-1:0] r_rs2;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [DW-1:0] r_res;
    logic          r_n;
    logic          r_z;
    logic          r_c;

    logic [DW-1:0] w_alu_res;
    logic          w_alu_c;
    logic          w_accept;

    logic          w_ready;
    logic [AW-1:0] w_r_adr;
    logic [AW-1:0] w_s_adr;
    logic [AW-1:0] w_w_adr;
    logic [DW-1:0] w_w;
    logic          w_we;
    logic          w_done;
    logic          w_err;

    assign w_accept = bus.op_valid && (r_state == IDLE);

    rf_seq_alu #(.DW(DW)) u_alu (
        .i_op  (r_op),
        .i_a   (r_a),
        .i_b   (r_b),
        .o_res (w_alu_res),
        .o_c   (w_alu_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op  <= '0;
            r_rd  <= '0;
            r_rs1 <= '0;
            r_rs2 <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
            r_n   <= 1'b0;
            r_z   <= 1'b0;
            r_c   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= bus.op_code;
                r_rd  <= bus.op_rd;
                r_rs1 <= bus.op_rs1;
                r_rs2 <= bus.op_rs2;
            end
            // Operands are captured before any write-back, so rd may alias
            // either source.
            if (r_state == READ) begin
                r_a <= bus.DA;
                r_b <= bus.DB;
            end
            if (r_state == EXEC) begin
                r_res <= w_alu_res;
                if (op_sets_nzc(r_op)) begin
                    r_n <= w_alu_res[DW-1];
                    r_z <= (w_alu_res == '0);
                    r_c <= w_alu_c;
                end else if (r_op == OP_CLR) begin
                    r_n <= 1'b0;
                    r_z <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_r_adr = '0;
        w_s_adr = '0;
        w_w_adr = '0;
        w_w     = '0;
        w_we    = 1'b0;
        w_done  = 1'b0;
        w_err   = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (bus.op_valid) begin
                    w_next = op_is_legal(bus.op_code) ? READ : ERR;
                end
            end
            READ: begin
                w_r_adr = r_rs1;
                w_s_adr = r_rs2;
                w_next  = EXEC;
            end
            EXEC: begin
                w_next = WB;
            end
            WB: begin
                w_we = 1'b1;
                // SWAP writes rs1 <= B here and rs2 <= A in WB2.
                if (r_op == OP_SWAP) begin
                    w_w_adr = r_rs1;
                    w_w     = r_b;
                    w_next  = WB2;
                end else begin
                    w_w_adr = r_rd;
                    w_w     = r_res;
                    w_done  = 1'b1;
                    w_next  = IDLE;
                end
            end
            WB2: begin
                w_we    = 1'b1;
                w_w_adr = r_rs2;
                w_w     = r_a;
                w_done  = 1'b1;
                w_next  = IDLE;
            end
            ERR: begin
                w_done = 1'b1;
                w_err  = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign bus.op_ready = w_ready;
    assign bus.R_Adr    = w_r_adr;
    assign bus.S_Adr    = w_s_adr;
    assign bus.W_Adr    = w_w_adr;
    assign bus.W        = w_w;
    assign bus.we       = w_we;
    assign bus.done     = w_done;
    assign bus.err      = w_err;
    assign bus.flag_n   = r_n;
    assign bus.flag_z   = r_z;
    assign bus.flag_c   = r_c;

endmodule

// File: tb/tb_rf_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rf_op_sequencer
//   Directed bench for rf_op_sequencer with a behavioural register file
//   (combinational reads, clocked write, preload bypass port).
// -----------------------------------------------------------------------------
module tb_rf_op_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_op_sequencer_if #(.DW(16), .AW(3)) bus ();

    rf_op_sequencer #(.DW(16), .AW(3)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    // Behavioural register file.
    logic [15:0] rf [0:7];
    logic        pl_we = 1'b0;
    logic [2:0]  pl_adr = '0;
    logic [15:0] pl_dat = '0;

    assign bus.DA = rf[bus.R_Adr];
    assign bus.DB = rf[bus.S_Adr];

    always @(posedge clk) begin
        if (pl_we) rf[pl_adr] <= pl_dat;
        else if (bus.we) rf[bus.W_Adr] <= bus.W;
    end

    // Cycle counter, write-pulse counter and accept log.
    int cyc = 0;
    int we_cnt = 0;
    int acc_n = 0;
    int acc_cyc [0:31];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.we) we_cnt <= we_cnt + 1;
        if (bus.op_valid && bus.op_ready) begin
            if (acc_n < 32) acc_cyc[acc_n] <= cyc;
            acc_n <= acc_n + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [2:0] a, input logic [15:0] d);
        pl_we = 1'b1; pl_adr = a; pl_dat = d;
        tick();
        pl_we = 1'b0;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [2:0] rd,
                          input logic [2:0] rs1, input logic [2:0] rs2);
        bus.op_code = op; bus.op_rd = rd; bus.op_rs1 = rs1; bus.op_rs2 = rs2;
    endtask

    // Offers one op for a single edge; returns in the cycle after acceptance.
    task automatic issue(input logic [3:0] op, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2);
        set_op(op, rd, rs1, rs2);
        bus.op_valid = 1'b1;
        tick();
        bus.op_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (bus.op_ready === 1'b1) break;
            tick();
        end
        check(tag, bus.op_ready, 1'b1);
    endtask

    int we_base;
    int acc_base;
    int k;
    logic [3:0] b_op  [0:2] = '{4'h1, 4'h5, 4'h7};
    logic [2:0] b_rd  [0:2] = '{3'd3, 3'd5, 3'd2};
    logic [2:0] b_rs1 [0:2] = '{3'd1, 3'd1, 3'd2};
    logic [2:0] b_rs2 [0:2] = '{3'd4, 3'd4, 3'd0};

    initial begin
        bus.op_valid = 1'b0;
        set_op(4'h0, 3'd0, 3'd0, 3'd0);

        // Reset state.
        #1;
        check("rst_ready", bus.op_ready, 1'b1);
        check("rst_we",    bus.we, 1'b0);
        check("rst_done",  bus.done, 1'b0);
        check("rst_err",   bus.err, 1'b0);
        check("rst_flags", {bus.flag_n, bus.flag_z, bus.flag_c}, 3'b000);
        check("rst_addr",  {bus.R_Adr, bus.S_Adr, bus.W_Adr}, 9'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // 1. ADD r3 = r1 + r2.
        preload(3'd1, 16'h1234);
        preload(3'd2, 16'h0101);
        issue(4'h1, 3'd3, 3'd1, 3'd2);
        check("t1_read_ready", bus.op_ready, 1'b0);
        check("t1_read_adr",   {bus.R_Adr, bus.S_Adr}, {3'd1, 3'd2});
        check("t1_read_we",    bus.we, 1'b0);
        tick();
        check("t1_exec_we",    bus.we, 1'b0);
        check("t1_exec_adr",   {bus.R_Adr, bus.S_Adr}, 6'd0);
        tick();
        check("t1_wb_we",      bus.we, 1'b1);
        check("t1_wb_done",    bus.done, 1'b1);
        check("t1_wb_wadr",    bus.W_Adr, 3'd3);
        check("t1_wb_w",       bus.W, 16'h1335);
        check("t1_flags",      {bus.flag_n, bus.flag_z, bus.flag_c}, 3'b000);
        tick();
        check("t1_idle_we",    bus.we, 1'b0);
        check("t1_idle_ready", bus.op_ready, 1'b1);
        check("t1_r3",         rf[3], 16'h1335);

        // 2. ADD wrap-around, then SUB with borrow.
        preload(3'd1, 16'hFFFF);
        preload(3'd2, 16'h0001);
        issue(4'h1, 3'd3, 3'd1, 3'd2);
        tick(); tick(); tick();
        check("t2_add_r3",    rf[3], 16'h0000);
        check("t2_add_flags", {bus.flag_n, bus.flag_z, bus.flag_c}, 3'b011);
        issue(4'h2, 3'd4, 3'd2, 3'd1);
        tick(); tick(); tick();
        check("t2_sub_r4",    rf[4], 16'h0002);
        check("t2_sub_flags", {bus.flag_n, bus.flag_z, bus.flag_c}, 3'b001);

        // 3. SWAP r5 <-> r6.
        preload(3'd5, 16'hAAAA);
        preload(3'd6, 16'h5555);
        we_base = we_cnt;
        issue(4'hB, 3'd0, 3'd5, 3'd6);
        check("t3_read_done", bus.done, 1'b0);
        tick();
        check("t3_exec_we",   bus.we, 1'b0);
        tick();
        check("t3_wb_we",     bus.we, 1'b1);
        check("t3_wb_done",   bus.done, 1'b0);
        check("t3_wb_write",  {bus.W_Adr, bus.W}, {3'd5, 16'h5555});
        tick();
        check("t3_wb2_we",    bus.we, 1'b1);
        check("t3_wb2_done",  bus.done, 1'b1);
        check("t3_wb2_write", {bus.W_Adr, bus.W}, {3'd6, 16'hAAAA});
        tick();
        check("t3_idle",      {bus.op_ready, bus.we, bus.done}, 3'b100);
        check("t3_r5",        rf[5], 16'h5555);
        check("t3_r6",        rf[6], 16'hAAAA);
        check("t3_we_count",  we_cnt - we_base, 2);
        check("t3_flags",     {bus.flag_n, bus.flag_z, bus.flag_c}, 3'b001);

        // 4. Illegal opcode 0xE.
        we_base = we_cnt;
        issue(4'hE, 3'd5, 3'd6, 3'd6);
        check("t4_err",       {bus.err, bus.done, bus.we}, 3'b110);
        check("t4_addr",      {bus.R_Adr, bus.S_Adr, bus.W_Adr}, 9'd0);
        tick();
        check("t4_after",     {bus.op_ready, bus.err, bus.done}, 3'b100);
        check("t4_flags",     {bus.flag_n, bus.flag_z, bus.flag_c}, 3'b001);
        check("t4_regs",      {rf[5], rf[6]}, {16'h5555, 16'hAAAA});
        check("t4_we_count",  we_cnt - we_base, 0);

        // 5. Reset during EXEC of MOV r7 = r0.
        preload(3'd0, 16'h0BEE);
        preload(3'd7, 16'h7777);
        we_base = we_cnt;
        issue(4'h0, 3'd7, 3'd0, 3'd0);
        tick();
        rst_n = 1'b0;
        #1;
        check("t5_abort_we",    bus.we, 1'b0);
        check("t5_abort_ready", bus.op_ready, 1'b1);
        check("t5_abort_flags", {bus.flag_n, bus.flag_z, bus.flag_c}, 3'b000);
        tick(); tick();
        check("t5_abort_writes", we_cnt - we_base, 0);
        check("t5_r7_kept",      rf[7], 16'h7777);
        rst_n = 1'b1;
        issue(4'h0, 3'd7, 3'd0, 3'd0);
        check("t5_accept",   {bus.op_ready, bus.R_Adr}, {1'b0, 3'd0});
        tick(); tick(); tick();
        check("t5_r7_mov",   rf[7], 16'h0BEE);
        check("t5_flags",    {bus.flag_n, bus.flag_z, bus.flag_c}, 3'b000);

        // 6. Back-to-back with op_valid held high.
        preload(3'd1, 16'h0003);
        preload(3'd4, 16'h0005);
        preload(3'd2, 16'h7FFF);
        acc_base = acc_n;
        k = 0;
        set_op(b_op[0], b_rd[0], b_rs1[0], b_rs2[0]);
        bus.op_valid = 1'b1;
        for (int i = 0; i < 40 && k < 3; i++) begin
            tick();
            if (acc_n - acc_base > k) begin
                k++;
                if (k < 3) set_op(b_op[k], b_rd[k], b_rs1[k], b_rs2[k]);
                else bus.op_valid = 1'b0;
            end
        end
        bus.op_valid = 1'b0;
        check("t6_accepts", acc_n - acc_base, 3);
        check("t6_gap1",    acc_cyc[acc_base + 1] - acc_cyc[acc_base], 4);
        check("t6_gap2",    acc_cyc[acc_base + 2] - acc_cyc[acc_base + 1], 4);
        wait_idle("t6_idle");
        check("t6_r3",      rf[3], 16'h0008);
        check("t6_r5",      rf[5], 16'h0006);
        check("t6_r2",      rf[2], 16'h8000);
        check("t6_flags",   {bus.flag_n, bus.flag_z, bus.flag_c}, 3'b100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
